// File: rtl/display_mux.sv
// display_mux: multiplexed seven-segment scanner with shadow/active banks.
// Define DISPLAY_BLINK_EN to build the per-digit blink counter.
module display_mux #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      WrValid,
  output logic                      WrReady,
  input  logic [$clog2(DIGITS)-1:0] WrAddr,
  input  logic [3:0]                WrData,
  input  logic                      WrDp,
  input  logic                      WrBlank,
  input  logic                      WrBlink,
  input  logic                      Commit,
  output logic [6:0]                Seg,
  output logic                      Dp,
  output logic [DIGITS-1:0]         DigitEn,
  output logic                      FrameStart
);

  localparam int AW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] D_LAST = AW'(DIGITS - 1);

  logic          run;
  logic          pending;
  logic [PW-1:0] presc;
  logic [AW-1:0] idx;
  logic          dark;
  logic          slot_end;
  logic          frame_end;
  logic          wr_hit;
  logic          cm_fire;
  logic          swap;
  logic          blink_off;

  logic [DIGITS-1:0][3:0] sh_val;
  logic [DIGITS-1:0][3:0] act_val;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      act_dp;
  logic [DIGITS-1:0]      sh_blank;
  logic [DIGITS-1:0]      act_blank;

  logic [6:0]        seg_d;
  logic              dp_d;
  logic              fs_d;
  logic [DIGITS-1:0] en_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  assign WrReady   = !pending;
  assign wr_hit    = WrValid && !pending
                   && (int'(WrAddr) < DIGITS);
  assign cm_fire   = Commit && !pending;
  assign dark      = (presc == P_LAST);
  assign slot_end  = run && dark;
  assign frame_end = slot_end && (idx == D_LAST);
  assign swap      = frame_end && pending;

  // run holds the counters for one cycle after reset release
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      run   <= 1'b0;
      presc <= '0;
      idx   <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (slot_end) begin
          presc <= '0;
          if (idx == D_LAST)
            idx <= '0;
          else
            idx <= idx + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      pending   <= 1'b0;
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
      act_val   <= '0;
      act_dp    <= '0;
      act_blank <= '1;
    end else begin
      if (wr_hit) begin
        sh_val[WrAddr]   <= WrData;
        sh_dp[WrAddr]    <= WrDp;
        sh_blank[WrAddr] <= WrBlank;
      end
      if (swap) begin
        act_val   <= sh_val;
        act_dp    <= sh_dp;
        act_blank <= sh_blank;
        pending   <= 1'b0;
      end else if (cm_fire) begin
        pending <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0]     bcnt;
  logic              bphase;
  logic [DIGITS-1:0] sh_blink;
  logic [DIGITS-1:0] act_blink;

  // bphase=0 is the on phase
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      bcnt      <= '0;
      bphase    <= 1'b0;
      sh_blink  <= '0;
      act_blink <= '0;
    end else begin
      if (wr_hit)
        sh_blink[WrAddr] <= WrBlink;
      if (swap)
        act_blink <= sh_blink;
      if (frame_end) begin
        if (bcnt == B_LAST) begin
          bcnt   <= '0;
          bphase <= !bphase;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  assign blink_off = bphase && act_blink[idx];
`else
  logic unused_blink;
  assign unused_blink = WrBlink ^ (BLINK_FRAMES == 0);
  assign blink_off    = 1'b0;
`endif

  always_comb begin
    seg_d = '0;
    dp_d  = 1'b0;
    en_d  = '0;
    fs_d  = 1'b0;
    if (run && !dark) begin
      en_d = DIGITS'(1) << idx;
      fs_d = (idx == '0) && (presc == '0);
      if (!act_blank[idx] && !blink_off) begin
        seg_d = hex7(act_val[idx]);
        dp_d  = act_dp[idx];
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      Seg        <= '0;
      Dp         <= 1'b0;
      DigitEn    <= '0;
      FrameStart <= 1'b0;
    end else begin
      Seg        <= seg_d;
      Dp         <= dp_d;
      DigitEn    <= en_d;
      FrameStart <= fs_d;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// tb_display_mux: table-driven writes/commits with a frame scoreboard.
// Also covers reset-while-pending and out-of-range writes on a 6-digit build.
module tb_display_mux;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FL = ND * SD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n  = 1'b0;
  logic       wv     = 1'b0;
  logic       c      = 1'b0;
  logic       wdp    = 1'b0;
  logic       wblank = 1'b0;
  logic       wblink = 1'b0;
  logic [1:0] wa     = '0;
  logic [3:0] wd     = '0;
  logic       wr;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] en;
  logic       fs;

  logic       v2   = 1'b0;
  logic       c2   = 1'b0;
  logic [2:0] a2   = '0;
  logic [3:0] d2   = '0;
  logic       dp2i = 1'b0;
  logic       r2;
  logic [6:0] seg2;
  logic       dp2o;
  logic [5:0] en2;
  logic       fs2;

  display_mux #(.DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(2)) dut (
    .Clock(clk), .ResetN(rst_n),
    .WrValid(wv), .WrReady(wr), .WrAddr(wa), .WrData(wd),
    .WrDp(wdp), .WrBlank(wblank), .WrBlink(wblink), .Commit(c),
    .Seg(seg), .Dp(dp), .DigitEn(en), .FrameStart(fs)
  );

  display_mux #(.DIGITS(6), .SCAN_DIV(SD), .BLINK_FRAMES(2)) dut6 (
    .Clock(clk), .ResetN(rst_n),
    .WrValid(v2), .WrReady(r2), .WrAddr(a2), .WrData(d2),
    .WrDp(dp2i), .WrBlank(1'b0), .WrBlink(1'b0), .Commit(c2),
    .Seg(seg2), .Dp(dp2o), .DigitEn(en2), .FrameStart(fs2)
  );

  typedef struct packed {
    int              fr;
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
    logic [3:0]      blk;
  } frm_t;

  typedef struct {
    logic [1:0] a;
    logic [3:0] d;
    logic       dp;
    logic       bl;
    logic       bk;
    int         cm;
    logic [6:0] es;
    logic       ed;
  } vec_t;

  frm_t exp_q[$];
  frm_t cur;
  frm_t want;
  vec_t tv[17];

  int n_cmp = 0;
  int n_bad = 0;
  int since = 0;
  int pcur  = -2;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // one clock; outputs of this edge compared against the frame scoreboard
  task automatic tick();
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fs;
    int p, dg, ph, fr;
    @(posedge clk);
    #1;
    e_en  = '0;
    e_seg = '0;
    e_dp  = 1'b0;
    e_fs  = 1'b0;
    if (!rst_n) since = 0;
    else since++;
    pcur = since - 2;
    if (since >= 2) begin
      p  = since - 2;
      dg = (p / SD) % ND;
      ph = p % SD;
      fr = p / FL;
      if (p % FL == 0 && exp_q.size() > 0 && exp_q[0].fr == fr)
        cur = exp_q.pop_front();
      if (ph != SD - 1) begin
        e_en  = 4'(1) << dg;
        e_fs  = (p % FL == 0);
        e_seg = cur.seg[dg];
        e_dp  = cur.dp[dg];
`ifdef DISPLAY_BLINK_EN
        if (cur.blk[dg] && ((fr / 2) % 2 == 1)) begin
          e_seg = '0;
          e_dp  = 1'b0;
        end
`endif
      end
    end
    n_cmp++;
    if (en !== e_en || seg !== e_seg || dp !== e_dp || fs !== e_fs) begin
      n_bad++;
      $display("FAIL scan p=%0d got en=%b seg=%h dp=%b fs=%b want en=%b seg=%h dp=%b fs=%b",
               pcur, en, seg, dp, fs, e_en, e_seg, e_dp, e_fs);
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic push_want();
    want.fr = (pcur + 1) / FL + 1;
    exp_q.push_back(want);
  endtask

  task automatic wait_commit();
    int  n = 0;
    bit  low_ok = 1'b1;
    do begin
      if (wr !== 1'b0) low_ok = 1'b0;
      tick();
      n++;
    end while (pcur % FL != FL - 1 && n < 40);
    chk("ready_low", low_ok, 1);
    chk("ready_back", wr, 1);
  endtask

  initial begin
    int bad, good;
    tv[0]  = '{2'd0, 4'h8, 1'b1, 1'b0, 1'b0, 0, 7'h7F, 1'b1};
    tv[1]  = '{2'd3, 4'hA, 1'b0, 1'b0, 1'b0, 1, 7'h77, 1'b0};
    tv[2]  = '{2'd1, 4'h3, 1'b0, 1'b0, 1'b0, 2, 7'h4F, 1'b0};
    tv[3]  = '{2'd2, 4'hE, 1'b1, 1'b0, 1'b1, 1, 7'h79, 1'b1};
    tv[4]  = '{2'd2, 4'h7, 1'b1, 1'b1, 1'b0, 1, 7'h00, 1'b0};
    tv[5]  = '{2'd0, 4'hF, 1'b0, 1'b0, 1'b0, 0, 7'h71, 1'b0};
    tv[6]  = '{2'd1, 4'hD, 1'b1, 1'b0, 1'b0, 2, 7'h5E, 1'b1};
    tv[7]  = '{2'd3, 4'h6, 1'b0, 1'b0, 1'b0, 0, 7'h7D, 1'b0};
    tv[8]  = '{2'd2, 4'h9, 1'b0, 1'b0, 1'b0, 1, 7'h6F, 1'b0};
    tv[9]  = '{2'd0, 4'hB, 1'b0, 1'b0, 1'b0, 0, 7'h7C, 1'b0};
    tv[10] = '{2'd1, 4'hC, 1'b0, 1'b0, 1'b0, 0, 7'h39, 1'b0};
    tv[11] = '{2'd2, 4'h2, 1'b0, 1'b0, 1'b0, 0, 7'h5B, 1'b0};
    tv[12] = '{2'd3, 4'h4, 1'b0, 1'b0, 1'b0, 1, 7'h66, 1'b0};
    tv[13] = '{2'd0, 4'h5, 1'b0, 1'b0, 1'b0, 0, 7'h6D, 1'b0};
    tv[14] = '{2'd1, 4'h0, 1'b1, 1'b0, 1'b0, 0, 7'h3F, 1'b1};
    tv[15] = '{2'd2, 4'h1, 1'b0, 1'b0, 1'b0, 0, 7'h06, 1'b0};
    tv[16] = '{2'd3, 4'h7, 1'b0, 1'b0, 1'b0, 1, 7'h07, 1'b0};

    cur  = '0;
    want = '0;
    tick();
    tick();
    chk("reset_ready", wr, 1);
    chk("reset_ready6", r2, 1);
    rst_n = 1'b1;
    run(2 * FL);

    for (int i = 0; i < 17; i++) begin
      wv     = 1'b1;
      wa     = tv[i].a;
      wd     = tv[i].d;
      wdp    = tv[i].dp;
      wblank = tv[i].bl;
      wblink = tv[i].bk;
      c      = (tv[i].cm == 2);
      want.seg[tv[i].a] = tv[i].es;
      want.dp[tv[i].a]  = tv[i].ed;
      want.blk[tv[i].a] = tv[i].bk;
      tick();
      wv     = 1'b0;
      c      = 1'b0;
      wblink = 1'b0;
      if (tv[i].cm == 1) begin
        c = 1'b1;
        tick();
        c = 1'b0;
      end
      if (tv[i].cm != 0) begin
        push_want();
        wait_commit();
      end
    end
    run(FL + 4);

    // writes are refused while a commit is pending
    c = 1'b1;
    tick();
    c = 1'b0;
    push_want();
    wv = 1'b1; wa = 2'd1; wd = 4'h5; wdp = 1'b1; wblank = 1'b0;
    chk("busy_ready", wr, 0);
    tick();
    wv = 1'b0;
    wait_commit();
    c = 1'b1;
    tick();
    c = 1'b0;
    push_want();
    wait_commit();
    run(FL + 4);

    // blinking digit 2
    wv = 1'b1; wa = 2'd2; wd = 4'h1; wdp = 1'b0; wblank = 1'b0;
    wblink = 1'b1; c = 1'b1;
    want.seg[2] = 7'h06;
    want.dp[2]  = 1'b0;
    want.blk[2] = 1'b1;
    tick();
    wv = 1'b0; c = 1'b0; wblink = 1'b0;
    push_want();
    wait_commit();
    run(5 * FL);

    // out-of-range address on the 6-digit build
    v2 = 1'b1; a2 = 3'd7; d2 = 4'h8; dp2i = 1'b1;
    chk("oor_ready", r2, 1);
    tick();
    a2 = 3'd5; d2 = 4'h1; dp2i = 1'b0;
    tick();
    v2 = 1'b0; c2 = 1'b1;
    tick();
    c2 = 1'b0;
    bad  = 0;
    good = 0;
    repeat (80) begin
      tick();
      if (en2 != 6'b100000 && (seg2 != 7'h00 || dp2o != 1'b0)) bad++;
      if (en2 == 6'b100000 && seg2 == 7'h06) good++;
    end
    chk("oor_discard", bad, 0);
    chk("in_range_write", good > 0, 1);

    // reset while a commit is pending
    wv = 1'b1; wa = 2'd0; wd = 4'h8; wdp = 1'b1; wblank = 1'b0;
    tick();
    wv = 1'b0; c = 1'b1;
    tick();
    c = 1'b0;
    run(3);
    rst_n = 1'b0;
    exp_q.delete();
    cur  = '0;
    want = '0;
    tick();
    chk("rst_pending_ready", wr, 1);
    rst_n = 1'b1;
    run(2 * FL);
    c = 1'b1;
    tick();
    c = 1'b0;
    push_want();
    wait_commit();
    run(FL + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
